// File: rtl/div_unit_radix.sv
// Iterative restoring divider: BITS_PER_CYCLE quotient bits per cycle, signed/unsigned, quotient or remainder.
// control = {alter_CR0, alter_OV, div_signed}; cr0_xer = {CR0_valid, CA_valid, CA, OV_valid, OV}. Define DIV_EARLY_OUT_EN to skip leading zeros.
module div_unit_radix #(
    parameter int RS_ID_WIDTH    = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [DATA_WIDTH-1:0]  op1,
    input  logic [DATA_WIDTH-1:0]  op2,
    input  logic [2:0]             control,
    input  logic                   rem_sel,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [DATA_WIDTH-1:0]  result,
    output logic [4:0]             cr0_xer
);

    // state | meaning
    // IDLE  | waiting for an operation, input_ready=1
    // PREP  | sign handling, special-case detection, shift register load
    // ITER  | BITS_PER_CYCLE restoring steps per cycle
    // DONE  | first cycle loads outputs, then holds until output_ready
    typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;

    localparam int W  = DATA_WIDTH;
    localparam int N  = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    state_t                 state_q;
    logic                   input_ready_q, output_valid_q;
    logic [RS_ID_WIDTH-1:0] rs_id_q, rs_id_out_q;
    logic [4:0]             addr_q, addr_out_q;
    logic [W-1:0]           op1_q, op2_q, a_q, b_q, acc_q, result_q;
    logic [2:0]             ctrl_q;
    logic                   rem_sel_q, quo_neg_q, rem_neg_q, ov_q;
    logic [CW-1:0]          cnt_q;
    logic [4:0]             cr0_xer_q;

    logic         s1, s2, div0, ovf, early_zero;
    logic [W-1:0] mag1, mag2, shifted_d, result_d;
    logic [CW-1:0] iters_d;
    logic [W:0]   acc_t;
    logic [W-1:0] a_t;

    assign s1   = ctrl_q[0] & op1_q[W-1];
    assign s2   = ctrl_q[0] & op2_q[W-1];
    assign mag1 = s1 ? -op1_q : op1_q;
    assign mag2 = s2 ? -op2_q : op2_q;
    assign div0 = (op2_q == '0);
    assign ovf  = ctrl_q[0] && (op1_q == {1'b1, {(W-1){1'b0}}}) && (&op2_q);

`ifdef DIV_EARLY_OUT_EN
    localparam int LZW     = $clog2(DATA_WIDTH + 1);
    localparam int LOG_BPC = $clog2(BITS_PER_CYCLE);
    logic [LZW-1:0] lz_d, lz_round;

    always_comb begin
        lz_d = LZW'(W);
        for (int i = 0; i < W; i++) begin
            if (mag1[i]) lz_d = LZW'(W - 1 - i);
        end
        lz_round   = lz_d & ~LZW'(BITS_PER_CYCLE - 1);
        shifted_d  = mag1 << lz_round;
        iters_d    = CW'(N) - CW'(lz_round >> LOG_BPC);
        early_zero = (mag1 == '0);
    end
`else
    assign shifted_d  = mag1;
    assign iters_d    = CW'(N);
    assign early_zero = 1'b0;
`endif

    // Shifted partial remainder can reach 2*divisor, hence one extra working bit.
    always_comb begin
        acc_t = {1'b0, acc_q};
        a_t   = a_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            acc_t = {acc_t[W-1:0], a_t[W-1]};
            a_t   = {a_t[W-2:0], 1'b0};
            if (acc_t >= {1'b0, b_q}) begin
                acc_t  = acc_t - {1'b0, b_q};
                a_t[0] = 1'b1;
            end
        end
    end

    always_comb begin
        result_d = '0;
        if (!ov_q) begin
            if (rem_sel_q) result_d = rem_neg_q ? -acc_q : acc_q;
            else           result_d = quo_neg_q ? -a_q : a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            input_ready_q  <= 1'b0;
            output_valid_q <= 1'b0;
            rs_id_q        <= '0;
            rs_id_out_q    <= '0;
            addr_q         <= '0;
            addr_out_q     <= '0;
            op1_q          <= '0;
            op2_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            acc_q          <= '0;
            result_q       <= '0;
            ctrl_q         <= '0;
            rem_sel_q      <= 1'b0;
            quo_neg_q      <= 1'b0;
            rem_neg_q      <= 1'b0;
            ov_q           <= 1'b0;
            cnt_q          <= '0;
            cr0_xer_q      <= '0;
        end else if (flush) begin
            state_q        <= IDLE;
            output_valid_q <= 1'b0;
            input_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    input_ready_q <= 1'b1;
                    if (input_valid && input_ready_q) begin
                        op1_q         <= op1;
                        op2_q         <= op2;
                        ctrl_q        <= control;
                        rem_sel_q     <= rem_sel;
                        rs_id_q       <= rs_id_in;
                        addr_q        <= result_reg_addr_in;
                        input_ready_q <= 1'b0;
                        state_q       <= PREP;
                    end
                end
                PREP: begin
                    quo_neg_q <= s1 ^ s2;
                    rem_neg_q <= s1;
                    b_q       <= mag2;
                    acc_q     <= '0;
                    a_q       <= shifted_d;
                    cnt_q     <= iters_d;
                    ov_q      <= div0 | ovf;
                    if (div0 || ovf || early_zero) state_q <= DONE;
                    else                           state_q <= ITER;
                end
                ITER: begin
                    acc_q <= acc_t[W-1:0];
                    a_q   <= a_t;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_q <= DONE;
                end
                DONE: begin
                    if (!output_valid_q) begin
                        result_q       <= result_d;
                        rs_id_out_q    <= rs_id_q;
                        addr_out_q     <= addr_q;
                        cr0_xer_q      <= {ctrl_q[2], 1'b0, 1'b0, ctrl_q[1], ov_q};
                        output_valid_q <= 1'b1;
                    end else if (output_ready) begin
                        output_valid_q <= 1'b0;
                        input_ready_q  <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign input_ready         = input_ready_q;
    assign output_valid        = output_valid_q;
    assign rs_id_out           = rs_id_out_q;
    assign result_reg_addr_out = addr_out_q;
    assign result              = result_q;
    assign cr0_xer             = cr0_xer_q;

endmodule

// File: doc/div_unit_radix.md
Name: div_unit_radix

Overview:
- Parametrised iterative integer divider for the fixed-point execution cluster.
- Consumes BITS_PER_CYCLE quotient bits per cycle over DATA_WIDTH-bit operands.
- Supports signed/unsigned divide, quotient or remainder selection, and a pipeline flush.
- Sits between a reservation station and the CDB arbiter using valid/ready handshakes; one operation in flight.

Parameters:
RS_ID_WIDTH, 5, reservation-station tag width
DATA_WIDTH, 32, operand/result width; multiple of BITS_PER_CYCLE, >= 8
BITS_PER_CYCLE, 2, quotient bits per iteration; legal 1, 2, 4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of in-flight op
input_valid  in  1  operation offered
input_ready  out  1  unit can accept
rs_id_in  in  RS_ID_WIDTH  tag
result_reg_addr_in  in  5  destination GPR
op1  in  DATA_WIDTH  dividend
op2  in  DATA_WIDTH  divisor
control  in  div_decode_t  div_signed, alter_OV, alter_CR0
rem_sel  in  1  1 = return remainder instead of quotient
output_valid  out  1  result held
output_ready  in  1  consumer accepts
rs_id_out  out  RS_ID_WIDTH  tag
result_reg_addr_out  out  5  destination
result  out  DATA_WIDTH  quotient or remainder, two's complement
cr0_xer  out  cond_exception_t  OV, OV_valid, CA=0, CA_valid=0, CR0_valid

Behaviour:
- Reset: one clock; asynchronous, active-low reset. All outputs, state and datapath registers clear to 0; state = IDLE.
- N = DATA_WIDTH/BITS_PER_CYCLE iterations.
- FSM states: IDLE, PREP, ITER, DONE.
- IDLE:
  - input_ready=1.
  - On input_valid: latch operands, tag, control and rem_sel; go to PREP.
- PREP (1 cycle):
  - If div_signed, convert operands to sign-magnitude.
  - Quotient sign = s1^s2; remainder sign = s1.
  - Special cases go directly to DONE with OV=1, result=0:
    - op2==0, signed or unsigned;
    - signed op1 = most-negative and op2 = -1.
  - Otherwise: clear accumulator, load dividend into the shift register, go to ITER.
- ITER:
  - Each cycle performs BITS_PER_CYCLE restoring steps.
  - Accumulator is DATA_WIDTH+1 bits.
  - After N cycles, go to DONE.
- DONE:
  - Output registers are loaded on entry.
  - result = quotient or remainder per rem_sel, negated back to two's complement when its sign is 1.
  - OV_valid=alter_OV; CR0_valid=alter_CR0; OV=0 on normal completion.
  - output_valid=1 and all outputs hold stable while output_ready=0.
  - On output_ready: output_valid clears next cycle, go to IDLE.
- Latency: accept edge to output_valid = N+2 cycles normally (18 for defaults); 2 cycles for special cases.
- Throughput: input_ready=1 only in IDLE; no accept during DONE.
- Flush:
  - In any state, flush forces IDLE and output_valid=0 on the next edge.
  - Flush wins over a simultaneous input_valid (operation not accepted) and over output_ready.
- Reset mid-operation: immediate abandon, no output.
- Remainder magnitude is always < divisor magnitude; quotient truncates toward zero.

Optional Feature:
- DIV_EARLY_OUT_EN defined:
  - In PREP, count leading zeros of the dividend magnitude, rounded down to a multiple of BITS_PER_CYCLE (L).
  - Pre-shift the dividend by L and run N - L/BITS_PER_CYCLE iterations.
  - A zero dividend with nonzero divisor goes straight to DONE (latency 2, result 0, OV=0).
  - Results are identical to the non-early-out build.
- Not defined: fixed N iterations; no leading-zero logic synthesised.

Test Plan:
1. Unsigned 100/7, rem_sel=0 -> result=14, OV=0, output_valid exactly 18 cycles after accept; same with rem_sel=1 -> result=2.
2. Signed 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD; rem_sel=1 -> 0xFFFFFFFF; signed 7/0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
3. Special cases, alter_OV=1:
   - 5/0 unsigned -> result 0, OV=1, OV_valid=1, 2-cycle latency.
   - Signed 0x80000000/0xFFFFFFFF -> result 0, OV=1.
   - Unsigned 0x80000000/0xFFFFFFFF -> result 0, OV=0.
4. Backpressure: hold output_ready=0 for 10 cycles after output_valid -> result/tag stable, input_ready=0 throughout; release -> one transfer, input_ready=1 next cycle.
5. Flush mid-ITER (cycle 5) with simultaneous input_valid -> no output_valid, input not accepted, input_ready=1 next cycle; a following 9/3 returns 3.
6. rst_n pulsed low mid-ITER -> all outputs 0 asynchronously; with DIV_EARLY_OUT_EN, 3/1 completes in 3 cycles and 0/5 in 2 cycles with correct results.
